imm_inserter: RTL and testbench
===============================

// Module: imm_inserter
// PURPOSE
//  Inverse of the immediate extender: packs an immediate value into the instruction
//  bit fields of a given format (RV32I and RVC), on top of a template instruction.
//  Used by debug program-buffer and trap-vector instruction generation.
//  Elastic valid/ready stage with a skid register; flags out-of-range and misaligned values.
// PARAMETERS
//  DWIDTH     32  width of imm_i; must be >= 32
//  ERR_CNT_W  8   width of the saturating error counter
// PORTS
//  clk_i             in   1          clock
//  rst_n_i           in   1          reset, asynchronous, active-low
//  valid_i           in   1          request valid
//  ready_o           out  1          request accepted when valid_i && ready_o (registered)
//  immediate_type_i  in   immediate_source_t  format (IMM_I..IMM_C16)
//  imm_i             in   DWIDTH     immediate value (two's complement)
//  instr_i           in   32         template; non-immediate bits pass through unchanged
//  valid_o           out  1          result valid
//  ready_i           in   1          downstream accepts when valid_o && ready_i
//  instr_o           out  32         template with immediate fields overwritten
//  err_range_o       out  1          imm_i not representable in the format (with instr_o)
//  err_align_o       out  1          low bits that the format forces to zero are nonzero (with instr_o)
//  err_cnt_o         out  ERR_CNT_W  accepted requests with any error, saturating
// BEHAVIOUR
//  - Reset: valid_o=0, ready_o=1, instr_o=0, err_*_o=0, err_cnt_o=0, skid empty.
//  - Field placement is the exact inverse of the extender bit mapping for every format.
//    Bits outside the format's fields come from instr_i. For RVC formats, [31:16] come from instr_i.
//  - Range/alignment rules: I,S signed 12; B signed 13, bit0=0; U imm[11:0]=0 and signed 32;
//    J signed 21, bit0=0; CJ signed 12, bit0=0; CJR imm must be 0 (no fields written);
//    CI signed 6; CIW unsigned 10, [1:0]=0; CLUI signed 18, [11:0]=0; CSPL,CSPS unsigned 8,
//    [1:0]=0; CLS unsigned 7, [1:0]=0; CB signed 9, bit0=0; C16 signed 10, [3:0]=0.
//    An unknown type is handled as IMM_I.
//  - On error: fields are still written from the truncated low bits. Both flags can be set together.
//  - Latency: 1 cycle from acceptance to valid_o when the output register is free.
//    Throughput is 1 per cycle.
//  - Skid: ready_o = skid empty.
//    If output is held (valid_o && !ready_i) and a request is accepted, it goes to the skid
//    and ready_o drops next cycle.
//    When output drains, skid moves to output and ready_o returns to 1.
//    Never more than 2 entries; no loss, no reorder.
//  - Outputs instr_o/err_* stay stable while valid_o && !ready_i.
//  - err_cnt_o increments on acceptance of an erroneous request and saturates at all-ones.
//  - Reset asserted mid-transfer: all entries dropped, outputs return to reset values at once.
// TESTING
//  - IMM_I, imm=0xFFFFFFFF, instr_i=0x00000013 -> instr_o=0xFFF00013, no errors, 1-cycle latency.
//  - IMM_B, imm=0x800, instr_i=0x00000063 -> instr_o=0x000000E3; imm=0x1000 -> err_range_o=1.
//  - IMM_U, imm=0x12345000, instr_i=0x37 -> 0x12345037; imm=0x12345001 -> err_align_o=1,
//    err_cnt_o increments.
//  - IMM_J, imm=0x1, instr_i=0x6F -> instr_o=0x0000006F, err_align_o=1.
//  - Backpressure: ready_i=0 for 3 cycles with back-to-back valid_i -> ready_o=0 after 2 accepted.
//    Both are delivered in order; no duplicates.
//  - Random legal (type, imm) for all 15 types -> imm_extender(instr_o) == imm_i.
//    Reset mid-stream -> valid_o=0 immediately.

Source files
------------

// File: rtl/imm_inserter.sv
// Immediate inserter: packs a two's-complement immediate into the bit fields
// of an RV32I or RVC instruction format on top of a template instruction.
// The result leaves through an elastic valid/ready stage with one skid entry.
//
// Handshake: a request transfers on any rising clk_i where valid_i && ready_o;
// a result transfers on any rising clk_i where valid_o && ready_i. A producer
// holds valid_i and its payload until it transfers. This stage holds valid_o
// and instr_o/err_* stable until the result transfers.
//
// immediate_type_i encoding:
//   0 I, 1 S, 2 B, 3 U, 4 J, 5 CJ, 6 CJR, 7 CI, 8 CIW, 9 CLUI,
//   10 CSPL, 11 CSPS, 12 CLS, 13 CB, 14 C16; 15 behaves as I.
module imm_inserter #(
  parameter int DWIDTH    = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [3:0]           immediate_type_i,
  input  logic [DWIDTH-1:0]    imm_i,
  input  logic [31:0]          instr_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [31:0]          instr_o,
  output logic                 err_range_o,
  output logic                 err_align_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam logic [3:0] IMM_I    = 4'd0;
  localparam logic [3:0] IMM_S    = 4'd1;
  localparam logic [3:0] IMM_B    = 4'd2;
  localparam logic [3:0] IMM_U    = 4'd3;
  localparam logic [3:0] IMM_J    = 4'd4;
  localparam logic [3:0] IMM_CJ   = 4'd5;
  localparam logic [3:0] IMM_CJR  = 4'd6;
  localparam logic [3:0] IMM_CI   = 4'd7;
  localparam logic [3:0] IMM_CIW  = 4'd8;
  localparam logic [3:0] IMM_CLUI = 4'd9;
  localparam logic [3:0] IMM_CSPL = 4'd10;
  localparam logic [3:0] IMM_CSPS = 4'd11;
  localparam logic [3:0] IMM_CLS  = 4'd12;
  localparam logic [3:0] IMM_CB   = 4'd13;
  localparam logic [3:0] IMM_C16  = 4'd14;

  // True when v fits an n-bit signed field: everything from bit n-1 up is a
  // copy of the sign.
  function automatic logic fits_signed(input logic [DWIDTH-1:0] v, input int n);
    logic [DWIDTH-1:0] top;
    top = $unsigned($signed(v) >>> (n - 1));
    return (&top) | ~(|top);
  endfunction

  // True when v fits an n-bit unsigned field.
  function automatic logic fits_unsigned(input logic [DWIDTH-1:0] v, input int n);
    return ((v >> n) == '0);
  endfunction

  // True when any of the low a bits are set.
  function automatic logic low_set(input logic [DWIDTH-1:0] v, input int a);
    logic [DWIDTH-1:0] m;
    m = (DWIDTH'(1) << a) - DWIDTH'(1);
    return |(v & m);
  endfunction

  logic        accept;
  logic        out_free;
  logic [31:0] ins_instr;
  logic        ins_range;
  logic        ins_align;

  logic        skid_valid;
  logic [31:0] skid_instr;
  logic        skid_range;
  logic        skid_align;

  assign ready_o  = ~skid_valid;
  assign accept   = valid_i & ready_o;
  assign out_free = ~valid_o | ready_i;

  // Overwrite the format's immediate fields in the template and classify errors;
  // fields are written from the truncated low bits even when a check fails.
  always_comb begin
    ins_instr = instr_i;
    ins_range = 1'b0;
    ins_align = 1'b0;
    case (immediate_type_i)
      IMM_S: begin
        ins_instr[31:25] = imm_i[11:5];
        ins_instr[11:7]  = imm_i[4:0];
        ins_range        = ~fits_signed(imm_i, 12);
      end
      IMM_B: begin
        ins_instr[31]    = imm_i[12];
        ins_instr[30:25] = imm_i[10:5];
        ins_instr[11:8]  = imm_i[4:1];
        ins_instr[7]     = imm_i[11];
        ins_range        = ~fits_signed(imm_i, 13);
        ins_align        = imm_i[0];
      end
      IMM_U: begin
        ins_instr[31:12] = imm_i[31:12];
        ins_range        = ~fits_signed(imm_i, 32);
        ins_align        = low_set(imm_i, 12);
      end
      IMM_J: begin
        ins_instr[31]    = imm_i[20];
        ins_instr[30:21] = imm_i[10:1];
        ins_instr[20]    = imm_i[11];
        ins_instr[19:12] = imm_i[19:12];
        ins_range        = ~fits_signed(imm_i, 21);
        ins_align        = imm_i[0];
      end
      IMM_CJ: begin
        ins_instr[12]   = imm_i[11];
        ins_instr[11]   = imm_i[4];
        ins_instr[10:9] = imm_i[9:8];
        ins_instr[8]    = imm_i[10];
        ins_instr[7]    = imm_i[6];
        ins_instr[6]    = imm_i[7];
        ins_instr[5:3]  = imm_i[3:1];
        ins_instr[2]    = imm_i[5];
        ins_range       = ~fits_signed(imm_i, 12);
        ins_align       = imm_i[0];
      end
      IMM_CJR: begin
        // No immediate field: any nonzero value cannot be encoded.
        ins_range = |imm_i;
      end
      IMM_CI: begin
        ins_instr[12]  = imm_i[5];
        ins_instr[6:2] = imm_i[4:0];
        ins_range      = ~fits_signed(imm_i, 6);
      end
      IMM_CIW: begin
        ins_instr[12:11] = imm_i[5:4];
        ins_instr[10:7]  = imm_i[9:6];
        ins_instr[6]     = imm_i[2];
        ins_instr[5]     = imm_i[3];
        ins_range        = ~fits_unsigned(imm_i, 10);
        ins_align        = low_set(imm_i, 2);
      end
      IMM_CLUI: begin
        ins_instr[12]  = imm_i[17];
        ins_instr[6:2] = imm_i[16:12];
        ins_range      = ~fits_signed(imm_i, 18);
        ins_align      = low_set(imm_i, 12);
      end
      IMM_CSPL: begin
        ins_instr[12]  = imm_i[5];
        ins_instr[6:4] = imm_i[4:2];
        ins_instr[3:2] = imm_i[7:6];
        ins_range      = ~fits_unsigned(imm_i, 8);
        ins_align      = low_set(imm_i, 2);
      end
      IMM_CSPS: begin
        ins_instr[12:9] = imm_i[5:2];
        ins_instr[8:7]  = imm_i[7:6];
        ins_range       = ~fits_unsigned(imm_i, 8);
        ins_align       = low_set(imm_i, 2);
      end
      IMM_CLS: begin
        ins_instr[12:10] = imm_i[5:3];
        ins_instr[6]     = imm_i[2];
        ins_instr[5]     = imm_i[6];
        ins_range        = ~fits_unsigned(imm_i, 7);
        ins_align        = low_set(imm_i, 2);
      end
      IMM_CB: begin
        ins_instr[12]    = imm_i[8];
        ins_instr[11:10] = imm_i[4:3];
        ins_instr[6:5]   = imm_i[7:6];
        ins_instr[4:3]   = imm_i[2:1];
        ins_instr[2]     = imm_i[5];
        ins_range        = ~fits_signed(imm_i, 9);
        ins_align        = imm_i[0];
      end
      IMM_C16: begin
        ins_instr[12]  = imm_i[9];
        ins_instr[6]   = imm_i[4];
        ins_instr[5]   = imm_i[6];
        ins_instr[4:3] = imm_i[8:7];
        ins_instr[2]   = imm_i[5];
        ins_range      = ~fits_signed(imm_i, 10);
        ins_align      = low_set(imm_i, 4);
      end
      default: begin
        // IMM_I and the unused encoding share the I layout.
        ins_instr[31:20] = imm_i[11:0];
        ins_range        = ~fits_signed(imm_i, 12);
      end
    endcase
  end

  // Output register plus skid entry: a request accepted while the output is
  // stalled parks in the skid; the skid drains into the output first.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_o     <= 1'b0;
      instr_o     <= '0;
      err_range_o <= 1'b0;
      err_align_o <= 1'b0;
      skid_valid  <= 1'b0;
      skid_instr  <= '0;
      skid_range  <= 1'b0;
      skid_align  <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        valid_o     <= 1'b1;
        instr_o     <= skid_instr;
        err_range_o <= skid_range;
        err_align_o <= skid_align;
        skid_valid  <= 1'b0;
      end else if (accept) begin
        valid_o     <= 1'b1;
        instr_o     <= ins_instr;
        err_range_o <= ins_range;
        err_align_o <= ins_align;
      end else begin
        valid_o <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_instr <= ins_instr;
      skid_range <= ins_range;
      skid_align <= ins_align;
    end
  end

  // Saturating count of accepted requests that carry any error.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_cnt_o <= '0;
    end else if (accept && (ins_range || ins_align) && !(&err_cnt_o)) begin
      err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_inserter.sv
// Bench for imm_inserter: directed vector table, backpressure/skid sequence,
// random legal round-trip through an independent extender, mid-stream reset
// and error-counter saturation.
module tb_imm_inserter;

  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  localparam logic [3:0] T_I = 4'd0,  T_S = 4'd1,  T_B = 4'd2,  T_U = 4'd3;
  localparam logic [3:0] T_J = 4'd4,  T_CJ = 4'd5, T_CJR = 4'd6, T_CI = 4'd7;
  localparam logic [3:0] T_CIW = 4'd8, T_CLUI = 4'd9, T_CSPL = 4'd10, T_CSPS = 4'd11;
  localparam logic [3:0] T_CLS = 4'd12, T_CB = 4'd13, T_C16 = 4'd14, T_BAD = 4'd15;

  logic          clk;
  logic          rst_n;
  logic          valid_i;
  logic          ready_o;
  logic [3:0]    immediate_type_i;
  logic [31:0]   imm_i;
  logic [31:0]   instr_i;
  logic          valid_o;
  logic          ready_i;
  logic [31:0]   instr_o;
  logic          err_range_o;
  logic          err_align_o;
  logic [CW-1:0] err_cnt_o;

  imm_inserter #(.DWIDTH(32), .ERR_CNT_W(CW)) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .valid_i          (valid_i),
    .ready_o          (ready_o),
    .immediate_type_i (immediate_type_i),
    .imm_i            (imm_i),
    .instr_i          (instr_i),
    .valid_o          (valid_o),
    .ready_i          (ready_i),
    .instr_o          (instr_o),
    .err_range_o      (err_range_o),
    .err_align_o      (err_align_o),
    .err_cnt_o        (err_cnt_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  int err_model = 0;
  // Entry: [70] random round-trip, [69:66] type, [65:34] imm,
  //        [33] range, [32] align, [31:0] exact instr.
  logic [70:0] exp_q[$];
  logic [70:0] mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference decoder: instruction bits back to the immediate value.
  function automatic logic [31:0] extend(input logic [3:0] t, input logic [31:0] i);
    case (t)
      T_S:    return {{20{i[31]}}, i[31:25], i[11:7]};
      T_B:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      T_U:    return {i[31:12], 12'b0};
      T_J:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      T_CJ:   return {{20{i[12]}}, i[12], i[8], i[10:9], i[6], i[7], i[2], i[11], i[5:3], 1'b0};
      T_CJR:  return 32'd0;
      T_CI:   return {{26{i[12]}}, i[12], i[6:2]};
      T_CIW:  return {22'b0, i[10:7], i[12:11], i[5], i[6], 2'b0};
      T_CLUI: return {{14{i[12]}}, i[12], i[6:2], 12'b0};
      T_CSPL: return {24'b0, i[3:2], i[12], i[6:4], 2'b0};
      T_CSPS: return {24'b0, i[8:7], i[12:9], 2'b0};
      T_CLS:  return {25'b0, i[5], i[12:10], i[6], 2'b0};
      T_CB:   return {{23{i[12]}}, i[12], i[6:5], i[2], i[11:10], i[4:3], 1'b0};
      T_C16:  return {{22{i[12]}}, i[12], i[4:3], i[5], i[2], i[6], 4'b0};
      default: return {{20{i[31]}}, i[31:20]};
    endcase
  endfunction

  function automatic logic [31:0] rnd_signed(input int n, input int a);
    logic signed [31:0] s;
    logic [31:0] m;
    s = $urandom;
    s = s <<< (32 - n);
    s = s >>> (32 - n);
    m = (32'd1 << a) - 32'd1;
    return s & ~m;
  endfunction

  function automatic logic [31:0] rnd_unsigned(input int n, input int a);
    logic [31:0] r;
    logic [31:0] m;
    r = $urandom & ((32'd1 << n) - 32'd1);
    m = (32'd1 << a) - 32'd1;
    return r & ~m;
  endfunction

  function automatic logic [31:0] rnd_legal(input logic [3:0] t);
    case (t)
      T_S:    return rnd_signed(12, 0);
      T_B:    return rnd_signed(13, 1);
      T_U:    return $urandom & 32'hFFFFF000;
      T_J:    return rnd_signed(21, 1);
      T_CJ:   return rnd_signed(12, 1);
      T_CJR:  return 32'd0;
      T_CI:   return rnd_signed(6, 0);
      T_CIW:  return rnd_unsigned(10, 2);
      T_CLUI: return rnd_signed(18, 12);
      T_CSPL: return rnd_unsigned(8, 2);
      T_CSPS: return rnd_unsigned(8, 2);
      T_CLS:  return rnd_unsigned(7, 2);
      T_CB:   return rnd_signed(9, 1);
      T_C16:  return rnd_signed(10, 4);
      default: return rnd_signed(12, 0);
    endcase
  endfunction

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [3:0] t, input logic [31:0] imm, input logic [31:0] tmpl,
                      input logic [70:0] e, input logic is_err);
    logic acc;
    int   n;
    valid_i = 1'b1;
    immediate_type_i = t;
    imm_i = imm;
    instr_i = tmpl;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = ready_o;
      @(posedge clk);
      #1;
      n++;
    end
    valid_i = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: ready_o low for %0d cycles, expected acceptance", n);
    end else begin
      exp_q.push_back(e);
      if (is_err && err_model < SAT) err_model++;
    end
  endtask

  function automatic logic [70:0] exact(input logic r, input logic a, input logic [31:0] ins);
    return {1'b0, 4'd0, 32'd0, r, a, ins};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (rst_n && valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got instr 0x%0h expected no output", instr_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e[70]) begin
          check($sformatf("rnd_roundtrip_t%0d", mon_e[69:66]), 64'(extend(mon_e[69:66], instr_o)),
                64'(mon_e[65:34]));
          check("rnd_no_err", 64'({err_range_o, err_align_o}), 64'd0);
        end else begin
          check("out_instr_flags", 64'({err_range_o, err_align_o, instr_o}), 64'(mon_e[33:0]));
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  t;
    logic [31:0] imm;
    logic [31:0] tmpl;
    logic [31:0] exp_instr;
    logic        exp_range;
    logic        exp_align;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] t, input logic [31:0] imm, input logic [31:0] tmpl,
                              input logic [31:0] ei, input logic er, input logic ea);
    vec_t v;
    v.t = t; v.imm = imm; v.tmpl = tmpl; v.exp_instr = ei; v.exp_range = er; v.exp_align = ea;
    return v;
  endfunction

  logic rnd_done;
  int   c0;
  logic [31:0] held;

  initial begin
    rst_n = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    immediate_type_i = '0;
    imm_i = '0;
    instr_i = '0;
    rnd_done = 1'b0;

    vecs.push_back(mk(T_I,    32'hFFFFFFFF, 32'h00000013, 32'hFFF00013, 0, 0));
    vecs.push_back(mk(T_I,    32'h00000000, 32'hFFFFFFFF, 32'h000FFFFF, 0, 0));
    vecs.push_back(mk(T_I,    32'h00000800, 32'h00000013, 32'h80000013, 1, 0));
    vecs.push_back(mk(T_S,    32'hFFFFFFF8, 32'h00002023, 32'hFE002C23, 0, 0));
    vecs.push_back(mk(T_B,    32'h00000800, 32'h00000063, 32'h000000E3, 0, 0));
    vecs.push_back(mk(T_B,    32'h00001000, 32'h00000063, 32'h80000063, 1, 0));
    vecs.push_back(mk(T_U,    32'h12345000, 32'h00000037, 32'h12345037, 0, 0));
    vecs.push_back(mk(T_U,    32'h12345001, 32'h00000037, 32'h12345037, 0, 1));
    vecs.push_back(mk(T_J,    32'h00000001, 32'h0000006F, 32'h0000006F, 0, 1));
    vecs.push_back(mk(T_J,    32'h00000800, 32'h0000006F, 32'h0010006F, 0, 0));
    vecs.push_back(mk(T_CJ,   32'h000007FE, 32'h0000A001, 32'h0000AFFD, 0, 0));
    vecs.push_back(mk(T_CJR,  32'h00000000, 32'h00008082, 32'h00008082, 0, 0));
    vecs.push_back(mk(T_CJR,  32'h00000004, 32'h00008082, 32'h00008082, 1, 0));
    vecs.push_back(mk(T_CI,   32'hFFFFFFFF, 32'hABCD0001, 32'hABCD107D, 0, 0));
    vecs.push_back(mk(T_CIW,  32'h000003FC, 32'h00000000, 32'h00001FE0, 0, 0));
    vecs.push_back(mk(T_CIW,  32'h00000402, 32'h00000000, 32'h00000000, 1, 1));
    vecs.push_back(mk(T_CLUI, 32'hFFFE0000, 32'h00006001, 32'h00007001, 0, 0));
    vecs.push_back(mk(T_CSPL, 32'h000000FC, 32'h00004002, 32'h0000507E, 0, 0));
    vecs.push_back(mk(T_CSPS, 32'h00000084, 32'h0000C002, 32'h0000C302, 0, 0));
    vecs.push_back(mk(T_CLS,  32'h00000044, 32'h00004000, 32'h00004060, 0, 0));
    vecs.push_back(mk(T_CB,   32'hFFFFFF00, 32'h0000C001, 32'h0000D001, 0, 0));
    vecs.push_back(mk(T_C16,  32'h000001F0, 32'h00006101, 32'h0000617D, 0, 0));
    vecs.push_back(mk(T_C16,  32'h00000208, 32'h00006101, 32'h00007101, 1, 1));
    vecs.push_back(mk(T_BAD,  32'h000007FF, 32'h00000013, 32'h7FF00013, 0, 0));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_o", 64'(valid_o), 64'd0);
    check("rst_ready_o", 64'(ready_o), 64'd1);
    check("rst_instr_o", 64'(instr_o), 64'd0);
    check("rst_err_flags", 64'({err_range_o, err_align_o}), 64'd0);
    check("rst_err_cnt", 64'(err_cnt_o), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table: one request at a time, 1-cycle latency and counter
    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].t, vecs[i].imm, vecs[i].tmpl,
           exact(vecs[i].exp_range, vecs[i].exp_align, vecs[i].exp_instr),
           vecs[i].exp_range | vecs[i].exp_align);
      @(negedge clk);
      check($sformatf("vec%0d_latency", i), 64'(valid_o), 64'd1);
      check($sformatf("vec%0d_err_cnt", i), 64'(err_cnt_o), 64'(err_model));
      @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;
    check("table_drained", 64'(exp_q.size()), 64'd0);

    // Throughput: back-to-back requests with no backpressure
    c0 = cyc;
    for (int i = 0; i < 8; i++)
      send(T_I, 32'(i), 32'h00000013, exact(1'b0, 1'b0, {12'(i), 20'h00013}), 1'b0);
    check("throughput_cycles", 64'(cyc - c0), 64'd8);
    repeat (3) @(posedge clk);
    #1;
    check("thru_drained", 64'(exp_q.size()), 64'd0);

    // Backpressure: two accepted, skid fills, ready_o drops, outputs hold
    ready_i = 1'b0;
    send(T_I, 32'd5, 32'h00000013, exact(1'b0, 1'b0, 32'h00500013), 1'b0);
    send(T_I, 32'd6, 32'h00000013, exact(1'b0, 1'b0, 32'h00600013), 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("bp_ready_low_%0d", k), 64'(ready_o), 64'd0);
      check($sformatf("bp_hold_%0d", k), 64'({valid_o, instr_o}), {31'd0, 1'b1, 32'h00500013});
    end
    @(posedge clk);
    #1;
    ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("bp_drained", 64'(exp_q.size()), 64'd0);
    check("bp_idle", 64'({valid_o, ready_o}), 64'b01);

    // Random legal immediates with random backpressure, checked by round-trip
    fork
      begin
        for (int t = 0; t < 15; t++)
          for (int k = 0; k < 4; k++) begin
            logic [31:0] v;
            v = rnd_legal(4'(t));
            send(4'(t), v, $urandom, {1'b1, 4'(t), v, 34'd0}, 1'b0);
          end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          ready_i = ($urandom_range(0, 3) != 0);
        end
      end
    join
    ready_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rnd_drained", 64'(exp_q.size()), 64'd0);

    // Reset mid-stream with both entries occupied
    ready_i = 1'b0;
    send(T_I, 32'h00000800, 32'h00000013, exact(1'b1, 1'b0, 32'h80000013), 1'b1);
    send(T_I, 32'h00000007, 32'h00000013, exact(1'b0, 1'b0, 32'h00700013), 1'b0);
    check("pre_rst_err_cnt", 64'(err_cnt_o), 64'(err_model));
    rst_n = 1'b0;
    #1;
    check("midrst_valid_o", 64'(valid_o), 64'd0);
    check("midrst_ready_o", 64'(ready_o), 64'd1);
    check("midrst_instr_o", 64'({err_range_o, err_align_o, instr_o}), 64'd0);
    check("midrst_err_cnt", 64'(err_cnt_o), 64'd0);
    exp_q.delete();
    err_model = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("post_rst_idle_%0d", k), 64'(valid_o), 64'd0);
    end
    @(posedge clk);
    #1;

    // Error counter saturation
    for (int i = 0; i < SAT + 2; i++)
      send(T_I, 32'h00000800, 32'h00000013, exact(1'b1, 1'b0, 32'h80000013), 1'b1);
    @(negedge clk);
    check("err_cnt_saturated", 64'(err_cnt_o), 64'(err_model));
    check("err_cnt_all_ones", 64'(err_cnt_o), 64'(SAT));
    repeat (3) @(posedge clk);
    #1;
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
